uart_frame_checker: RTL and testbench
=====================================

UART_FRAME_CHECKER -- requirements
Module: uart_frame_checker

Interface
REQ-001 Parameter _PAYLOAD_LEN, default 11: payload bytes per frame, legal range 1..16.
REQ-002 Parameter _HEADER, default 8'hA5: frame start byte.
REQ-003 Parameter _TIMEOUT_CYC, default 50000: maximum idle clocks allowed between bytes inside a frame (1 ms at 50 MHz).
REQ-004 Port sys_clk, input, 1 bit: the single clock (50 MHz domain).
REQ-005 Port sys_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port uart_data, input, 8 bits: received byte, valid only while uart_done is high.
REQ-007 Port uart_done, input, 1 bit: one-cycle byte strobe from the UART receiver.
REQ-008 Port frame_data, output, _PAYLOAD_LEN*8 bits: payload; byte 0 (the func_reg byte) sits in bits [7:0].
REQ-009 Port frame_valid, output, 1 bit: one-cycle pulse marking a good frame.
REQ-010 Port crc_err, output, 1 bit: one-cycle pulse on CRC mismatch.
REQ-011 Port timeout_err, output, 1 bit: one-cycle pulse on inter-byte timeout.
REQ-012 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 Port good_cnt, output, 8 bits: count of good frames, wraps 255 to 0.
REQ-014 Port err_cnt, output, 8 bits: count of CRC and timeout errors, saturates at 255.

Function
REQ-015 FSM states: IDLE, PAYLOAD, CHECK, DONE.
- IDLE goes to PAYLOAD on uart_done with uart_data == _HEADER.
- IDLE ignores any other byte.
REQ-016 PAYLOAD stores each strobed byte into a shadow buffer at index byte_idx, then increments byte_idx.
- After byte _PAYLOAD_LEN-1 it goes to CHECK when FRAME_CRC_EN is defined, otherwise to DONE.
REQ-017 CHECK takes the next strobed byte as the received CRC.
- On match it goes to DONE.
- On mismatch it pulses crc_err, increments err_cnt and returns to IDLE.
REQ-018 DONE lasts exactly one cycle.
- Copies the shadow buffer into frame_data.
- Pulses frame_valid and increments good_cnt.
- Returns to IDLE.
REQ-019 Latency: frame_valid asserts exactly 2 clocks after the uart_done of the last frame byte.
REQ-020 frame_data changes only in DONE and holds its value through errors and partial frames.
REQ-021 An idle counter runs in PAYLOAD and CHECK and clears on every uart_done.
- On reaching _TIMEOUT_CYC it pulses timeout_err, increments err_cnt and returns to IDLE with no frame_data update.
REQ-022 A header value arriving mid-frame is treated as payload data, not as a resync.
REQ-023 A uart_done arriving in the DONE cycle is processed as an IDLE-state byte in that same cycle.
- A header byte there therefore starts a new frame.
REQ-024 CRC-8: polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR.
- Computed over payload bytes only; the header is excluded.
- Updated one byte per strobe.
REQ-025 err_cnt never wraps; good_cnt wraps modulo 256.

Reset
REQ-026 Asynchronous assertion of sys_rst_n low forces all of the following; this applies mid-frame as well:
- state IDLE, byte_idx 0, idle counter 0, CRC register 0x00;
- frame_data all zeros, frame_valid/crc_err/timeout_err/busy 0, good_cnt 0, err_cnt 0.
REQ-027 Bytes received before reset deasserts are discarded; the first post-reset frame needs a fresh header.

Configuration
REQ-028 Macro FRAME_CRC_EN, when defined:
- frame = header + _PAYLOAD_LEN bytes + CRC byte;
- the CHECK state and CRC logic are present.
REQ-029 Macro FRAME_CRC_EN, when undefined:
- frame = header + _PAYLOAD_LEN bytes;
- CHECK state and CRC logic are removed;
- crc_err is tied to 0;
- PAYLOAD goes straight to DONE.

Structure
REQ-030 Package uart_proto_pkg holds the shared frame definitions:
- header constant;
- CRC polynomial and init value;
- FSM state encoding;
- default payload length and timeout.
REQ-031 Package uart_proto_pkg is shared with uart_protocol_tx so that TX and RX agree on framing.
REQ-032 Sub-module crc8_byte is purely combinational: (crc_in, data_in) -> crc_out.
- It is instantiated once here.
- It is reusable by the TX path.

Verification
REQ-033 Good frame (FRAME_CRC_EN defined): bytes A5, eleven 00, then 00.
- Required: frame_valid pulse, frame_data = 0, good_cnt = 1.
REQ-034 Bad CRC (FRAME_CRC_EN defined): bytes A5, eleven 00, then 01.
- Required: crc_err pulse, err_cnt = 1, frame_data unchanged, no frame_valid.
REQ-035 Timeout: A5, three bytes, then no strobe for 50000 clocks.
- Required: timeout_err pulse on clock 50000, state IDLE, busy = 0.
REQ-036 Reset mid-frame after 5 payload bytes, then a complete good frame.
- Required: exactly one frame_valid, good_cnt = 1.
REQ-037 Junk then frame: bytes 3C, 00 before A5 + payload 01..0B + CRC.
- Required: junk ignored, frame_data[7:0] = 01 and [87:80] = 0B.
- Also run the same sequence with FRAME_CRC_EN undefined and no CRC byte sent; required: identical result.
REQ-038 err_cnt saturation: 300 consecutive bad-CRC frames.
- Required: err_cnt = 255 and holds.

Source files
------------

// File: rtl/uart_proto_pkg.sv
// Shared framing definitions for the UART protocol RX checker and TX builder.
// The optional CRC byte is selected by FRAME_CRC_EN in the modules that import this.
package uart_proto_pkg;

    localparam logic [7:0]  FRAME_HEADER    = 8'hA5;
    localparam logic [7:0]  CRC8_POLY       = 8'h07;
    localparam logic [7:0]  CRC8_INIT       = 8'h00;
    localparam int unsigned DEF_PAYLOAD_LEN = 11;
    localparam int unsigned DEF_TIMEOUT_CYC = 50000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } frame_state_t;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 step (MSB first, no reflection), purely combinational.
// Shared by the RX frame checker and the TX frame builder.
module crc8_byte
    import uart_proto_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ data_in;
        for (int unsigned i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC8_POLY) : (crc_out << 1);
        end
    end

endmodule

// File: rtl/uart_frame_checker.sv
// Receives header + payload (+ CRC-8 when FRAME_CRC_EN is defined) from a UART byte
// stream, publishes good payloads on frame_data and flags CRC / inter-byte timeout errors.
module uart_frame_checker
    import uart_proto_pkg::*;
#(
    parameter int unsigned _PAYLOAD_LEN = DEF_PAYLOAD_LEN,
    parameter logic [7:0]  _HEADER      = FRAME_HEADER,
    parameter int unsigned _TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [7:0]                uart_data,
    input  logic                      uart_done,
    output logic [_PAYLOAD_LEN*8-1:0] frame_data,
    output logic                      frame_valid,
    output logic                      crc_err,
    output logic                      timeout_err,
    output logic                      busy,
    output logic [7:0]                good_cnt,
    output logic [7:0]                err_cnt
);

    localparam int unsigned IDX_W = (_PAYLOAD_LEN > 1) ? $clog2(_PAYLOAD_LEN) : 1;
    localparam int unsigned TO_W  = $clog2(_TIMEOUT_CYC + 1);

    frame_state_t              state;
    frame_state_t              state_nxt;
    logic [IDX_W-1:0]          byte_idx;
    logic [TO_W-1:0]           idle_cnt;
    logic [_PAYLOAD_LEN*8-1:0] shadow;

    logic hdr_seen;
    logic last_byte;
    logic idle_expire;
    logic in_frame;
    logic take_byte;
    logic set_done;
    logic set_timeout;
    logic err_event;

    assign hdr_seen    = uart_done && (uart_data == _HEADER);
    assign last_byte   = (byte_idx == IDX_W'(_PAYLOAD_LEN - 1));
    assign idle_expire = !uart_done && (idle_cnt == TO_W'(_TIMEOUT_CYC - 1));

`ifdef FRAME_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_nxt;
    logic       crc_match;
    logic       set_crc_err;

    crc8_byte u_crc8 (
        .crc_in  (crc_q),
        .data_in (uart_data),
        .crc_out (crc_nxt)
    );

    assign crc_match = (uart_data == crc_q);
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE shares IDLE's header detection so a header strobed during DONE starts a new frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = hdr_seen ? PAYLOAD : IDLE;
            PAYLOAD: begin
                if (idle_expire) begin
                    state_nxt = IDLE;
                end else if (uart_done && last_byte) begin
`ifdef FRAME_CRC_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef FRAME_CRC_EN
            CHECK: begin
                if (idle_expire) begin
                    state_nxt = IDLE;
                end else if (uart_done) begin
                    state_nxt = crc_match ? DONE : IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        in_frame    = (state == PAYLOAD) || (state == CHECK);
        take_byte   = (state == PAYLOAD) && uart_done;
        set_done    = (state == DONE);
        set_timeout = in_frame && idle_expire;
        err_event   = set_timeout;
`ifdef FRAME_CRC_EN
        set_crc_err = (state == CHECK) && uart_done && !crc_match;
        err_event   = set_timeout || set_crc_err;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx    <= '0;
            idle_cnt    <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            good_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= set_done;
            timeout_err <= set_timeout;

            if (!in_frame || uart_done) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (take_byte) begin
                for (int unsigned i = 0; i < _PAYLOAD_LEN; i++) begin
                    if (byte_idx == IDX_W'(i)) begin
                        shadow[i*8 +: 8] <= uart_data;
                    end
                end
                byte_idx <= byte_idx + 1'b1;
            end else if (!in_frame) begin
                byte_idx <= '0;
            end

            if (set_done) begin
                frame_data <= shadow;
                good_cnt   <= good_cnt + 8'd1;
            end

            if (err_event && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef FRAME_CRC_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_q   <= CRC8_INIT;
            crc_err <= 1'b0;
        end else begin
            crc_err <= set_crc_err;
            if (take_byte) begin
                crc_q <= crc_nxt;
            end else if (!in_frame) begin
                crc_q <= CRC8_INIT;
            end
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_checker.sv
// Scoreboard bench for uart_frame_checker; adapts frame layout to FRAME_CRC_EN.
module tb_uart_frame_checker;

    localparam int unsigned LEN = 11;
    localparam int unsigned TO  = 50000;
    localparam int unsigned W   = LEN * 8;

    localparam logic [2:0] EV_GOOD = 3'b100;
    localparam logic [2:0] EV_CRC  = 3'b010;
    localparam logic [2:0] EV_TMO  = 3'b001;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [7:0]   uart_data = 8'h00;
    logic         uart_done = 1'b0;
    logic [W-1:0] frame_data;
    logic         frame_valid, crc_err, timeout_err, busy;
    logic [7:0]   good_cnt, err_cnt;

    logic [7:0]   f_data = 8'h00;
    logic         f_done = 1'b0;
    logic [15:0]  f_frame_data;
    logic         f_frame_valid, f_crc_err, f_timeout_err, f_busy;
    logic [7:0]   f_good_cnt, f_err_cnt;

    uart_frame_checker #(
        ._PAYLOAD_LEN (LEN),
        ._HEADER      (8'hA5),
        ._TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_data   (uart_data),
        .uart_done   (uart_done),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .crc_err     (crc_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
    );

    // Short-timeout instance so error-counter saturation is reachable in every build.
    uart_frame_checker #(
        ._PAYLOAD_LEN (2),
        ._HEADER      (8'hA5),
        ._TIMEOUT_CYC (16)
    ) u_fast (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_data   (f_data),
        .uart_done   (f_done),
        .frame_data  (f_frame_data),
        .frame_valid (f_frame_valid),
        .crc_err     (f_crc_err),
        .timeout_err (f_timeout_err),
        .busy        (f_busy),
        .good_cnt    (f_good_cnt),
        .err_cnt     (f_err_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   kind;
        logic [W-1:0] data;
        logic [7:0]   good;
        logic [7:0]   err;
        int           at;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           last_s = 0;
    int           f_tmo_seen = 0;
    logic [W-1:0] m_data = '0;
    logic [7:0]   m_good = 8'h00;
    logic [7:0]   m_err  = 8'h00;

    localparam logic [W-1:0] PL_ZERO = '0;
    localparam logic [W-1:0] PL_SEQ  = 88'h0B_0A_09_08_07_06_05_04_03_02_01;
    localparam logic [W-1:0] PL_HDR  = 88'hA5_00_00_00_00_00_00_00_00_00_00;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_ev(input logic [2:0] kind, input int at);
        exp_t e;
        e.kind = kind;
        e.data = m_data;
        e.good = m_good;
        e.err  = m_err;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    function automatic void bump_err();
        if (m_err != 8'hFF) m_err++;
    endfunction

    always @(negedge sys_clk) begin
        if (frame_valid || crc_err || timeout_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %b at cycle %0d expected none",
                         {frame_valid, crc_err, timeout_err}, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind",  {frame_valid, crc_err, timeout_err}, mon_e.kind);
                check("event_cycle", cyc, mon_e.at);
                check("frame_data",  frame_data, mon_e.data);
                check("good_cnt",    good_cnt, mon_e.good);
                check("err_cnt",     err_cnt, mon_e.err);
            end
        end
        if (f_timeout_err) f_tmo_seen++;
        if (f_frame_valid || f_crc_err) begin
            checks++;
            errors++;
            $display("FAIL fast_unexpected: got valid=%b crc=%b expected 0", f_frame_valid, f_crc_err);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns 1 ns after the edge that sampled the byte.
    task automatic strobe(input logic [7:0] b, input int gap);
        uart_data = b;
        uart_done = 1'b1;
        @(posedge sys_clk);
        #1;
        last_s    = cyc;
        uart_done = 1'b0;
        idle(gap);
    endtask

    task automatic send_frame(input logic [W-1:0] pl, input logic [7:0] crc);
        strobe(8'hA5, 1);
        for (int i = 0; i < LEN; i++) begin
`ifdef FRAME_CRC_EN
            strobe(pl[i*8 +: 8], 1);
`else
            strobe(pl[i*8 +: 8], (i == LEN - 1) ? 0 : 1);
`endif
        end
`ifdef FRAME_CRC_EN
        strobe(crc, 0);
`else
        if (crc == 8'hFF) check("crc_arg_unused", crc, 8'h00);
`endif
    endtask

    task automatic good_frame(input logic [W-1:0] pl, input logic [7:0] crc);
        send_frame(pl, crc);
        m_good++;
        m_data = pl;
        push_ev(EV_GOOD, last_s + 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_frame_data"},  frame_data, '0);
        check({tag, "_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_crc_err"},     crc_err, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
        check({tag, "_busy"},        busy, 1'b0);
        check({tag, "_good_cnt"},    good_cnt, 8'h00);
        check({tag, "_err_cnt"},     err_cnt, 8'h00);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_state("reset");
        #5 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        idle(2);

        good_frame(PL_ZERO, 8'h00);
        idle(4);

        strobe(8'h3C, 1);
        strobe(8'h00, 1);
        good_frame(PL_SEQ, 8'h44);
        idle(4);
        check("seq_byte0",  frame_data[7:0], 8'h01);
        check("seq_byte10", frame_data[87:80], 8'h0B);

`ifdef FRAME_CRC_EN
        send_frame(PL_ZERO, 8'h01);
        bump_err();
        push_ev(EV_CRC, last_s);
        idle(4);
`endif

        // Header value inside payload, then a new header strobed during DONE.
        good_frame(PL_HDR, 8'h72);
        good_frame(PL_SEQ, 8'h44);
        idle(4);

        strobe(8'hA5, 1);
        strobe(8'h11, 1);
        strobe(8'h22, 1);
        strobe(8'h33, 0);
        bump_err();
        push_ev(EV_TMO, last_s + TO);
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        check("busy_before_timeout", busy, 1'b1);
        @(posedge sys_clk);
        #1;
        check("busy_after_timeout", busy, 1'b0);
        idle(3);

        strobe(8'hA5, 1);
        for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i), 1);
        #5 sys_rst_n = 1'b0;
        #1;
        check_reset_state("midframe_reset");
        @(posedge sys_clk);
        #1;
        strobe(8'hA5, 1);
        strobe(8'h00, 1);
        m_good = 8'h00;
        m_err  = 8'h00;
        m_data = '0;
        #5 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        idle(2);
        good_frame(PL_SEQ, 8'h44);
        idle(4);
        check("good_after_reset", good_cnt, 8'h01);

`ifdef FRAME_CRC_EN
        for (int i = 0; i < 300; i++) begin
            send_frame(PL_ZERO, 8'h01);
            bump_err();
            push_ev(EV_CRC, last_s);
        end
        idle(4);
        check("err_cnt_saturated", err_cnt, 8'hFF);
        good_frame(PL_ZERO, 8'h00);
        idle(4);
        check("err_cnt_holds", err_cnt, 8'hFF);
`endif

        for (int i = 0; i < 300; i++) begin
            f_data = 8'hA5;
            f_done = 1'b1;
            @(posedge sys_clk);
            #1;
            f_done = 1'b0;
            idle(20);
            check("fast_err_cnt", f_err_cnt, (i + 1 > 255) ? 8'hFF : 8'(i + 1));
        end
        check("fast_timeouts", f_tmo_seen, 300);
        check("fast_good_cnt", f_good_cnt, 8'h00);
        check("fast_frame_data", f_frame_data, 16'h0000);
        check("fast_busy", f_busy, 1'b0);

        idle(4);
        check("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
